// File: rtl/gems2mm_reader_if.sv
// gems2mm_reader_if: AXI-Stream input and AXI4 read channels of the stream-to-MM reader
interface gems2mm_reader_if #(parameter int ID_W = 1);
    logic [31:0]     S_AXIS_TDATA;
    logic            S_AXIS_TLAST;
    logic            S_AXIS_TVALID;
    logic            S_AXIS_TREADY;
    logic [ID_W-1:0] S_AXI_ARID;
    logic [12:0]     S_AXI_ARADDR;
    logic [7:0]      S_AXI_ARLEN;
    logic [2:0]      S_AXI_ARSIZE;
    logic [1:0]      S_AXI_ARBURST;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [ID_W-1:0] S_AXI_RID;
    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;
    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TVALID,
        output S_AXIS_TREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
    modport master (
        output S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TVALID,
        input  S_AXIS_TREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/gems2mm_reader.sv
// gems2mm_reader: AXI-Stream capture FIFO drained by AXI4 read bursts, with a status word
module gems2mm_reader #(
    parameter int C_AXI_ID_WIDTH = 1,
    parameter int FIFO_AW        = 9
) (
    input logic             ACLK,
    input logic             ARESETN,
    gems2mm_reader_if.slave s
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, DATA, STAT, ERR} state_t;
    state_t                    state_q, state_d;
    logic [32:0]               mem_q [DEPTH];
    logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]          fill_q, fill_d;
    logic                      tready_q, tready_d, arready_q, arready_d;
    logic [8:0]                left_q, left_d;
    logic [C_AXI_ID_WIDTH-1:0] rid_q, rid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      rlast_q, rlast_d, rvalid_q, rvalid_d;
    logic                      push, pop, room, load;
    logic [32:0]               head;
    logic                      unused_bits;
    assign unused_bits     = ^{s.S_AXI_ARADDR[11:0], s.S_AXI_ARBURST[0]};
    assign s.S_AXIS_TREADY = tready_q;
    assign s.S_AXI_ARREADY = arready_q;
    assign s.S_AXI_RID     = rid_q;
    assign s.S_AXI_RDATA   = rdata_q;
    assign s.S_AXI_RRESP   = rresp_q;
    assign s.S_AXI_RLAST   = rlast_q;
    assign s.S_AXI_RVALID  = rvalid_q;
    // Next state: fill counts words until their beat is accepted, rd_ptr runs ahead to the word being loaded
    always_comb begin
        head      = mem_q[rd_ptr_q];
        push      = s.S_AXIS_TVALID && tready_q;
        pop       = state_q == DATA && rvalid_q && s.S_AXI_RREADY;
        room      = rvalid_q ? fill_q > (FIFO_AW+1)'(1) : fill_q != '0;
        load      = state_q != IDLE && left_q != '0 && (!rvalid_q || s.S_AXI_RREADY) && (state_q != DATA || room);
        state_d   = state_q;
        left_d    = left_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rvalid_d  = rvalid_q;
        wr_ptr_d  = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d  = load && state_q == DATA ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        fill_d    = fill_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        tready_d  = fill_d != (FIFO_AW+1)'(DEPTH);
        if (arready_q && s.S_AXI_ARVALID) begin
            rid_d   = s.S_AXI_ARID;
            left_d  = {1'b0, s.S_AXI_ARLEN} + 9'd1;
            state_d = (s.S_AXI_ARSIZE != 3'b010 || s.S_AXI_ARBURST[1]) ? ERR : s.S_AXI_ARADDR[12] ? STAT : DATA;
        end
        if (load) begin
            left_d   = left_q - 9'd1;
            rvalid_d = 1'b1;
            rlast_d  = left_q == 9'd1;
            rresp_d  = state_q == ERR ? 2'b10 : 2'b00;
            rdata_d  = state_q == DATA ? head[31:0] :
                       state_q == STAT ? {fill_q != '0 && head[32], 15'b0, 16'(fill_q)} : 32'b0;
        end else if (rvalid_q && s.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (rvalid_q && s.S_AXI_RREADY && rlast_q) state_d = IDLE;
        arready_d = state_d == IDLE;
    end
    // State registers; reset flushes the FIFO and abandons any burst
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            tready_q  <= 1'b0;
            arready_q <= 1'b0;
            left_q    <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            tready_q  <= tready_d;
            arready_q <= arready_d;
            left_q    <= left_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
        end
    end
    // FIFO storage: {TLAST, TDATA} per accepted stream word
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= {s.S_AXIS_TLAST, s.S_AXIS_TDATA};
    end
endmodule
